// File: rtl/signed_divider_pkg.sv
// Shared definitions for the iterative RV32M divide unit: FSM state encoding
// and the iteration-counter width helper.
package signed_divider_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PREP   = 3'd1,
        DIVIDE = 3'd2,
        FIXUP  = 3'd3,
        DONE   = 3'd4
    } divState_e;

    localparam int DEFAULT_NUM_SIZE = 32;

    function automatic int cntWidth(input int numSize);
        return (numSize <= 2) ? 1 : $clog2(numSize);
    endfunction

endpackage

// File: rtl/signed_divider_sign_magnitude.sv
// Two's-complement to sign + magnitude decoder. forceNeg turns it into a plain
// negator so the same logic re-encodes results to two's complement.
module sign_magnitude #(
    parameter int NUM_SIZE = 32
) (
    input  logic [NUM_SIZE-1:0] x,
    input  logic                isSigned,
    input  logic                forceNeg,
    output logic                sign,
    output logic [NUM_SIZE-1:0] mag
);

    // Negate when the operand is negative, or when negation is requested outright
    always_comb begin
        sign = isSigned & x[NUM_SIZE-1];
        if (sign || forceNeg) begin
            mag = ~x + NUM_SIZE'(1);
        end else begin
            mag = x;
        end
    end

endmodule

// File: rtl/signed_divider.sv
// Iterative restoring divider (DIV/DIVU/REM/REMU), one quotient bit per cycle,
// fixed latency of NUM_SIZE+3 cycles from accepted start to done.
module signed_divider
    import signed_divider_pkg::*;
#(
    parameter int NUM_SIZE = DEFAULT_NUM_SIZE
) (
    input  logic                clk,
    input  logic                rstN,
    input  logic                start,
    input  logic                isSigned,
    input  logic [NUM_SIZE-1:0] dividend,
    input  logic [NUM_SIZE-1:0] divisor,
    output logic                busy,
    output logic                done,
    output logic [NUM_SIZE-1:0] quotient,
    output logic [NUM_SIZE-1:0] remainder
);

    localparam int CNT_W = cntWidth(NUM_SIZE);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(NUM_SIZE - 1);
    localparam logic [NUM_SIZE-1:0] MIN_NEG  = {1'b1, {(NUM_SIZE-1){1'b0}}};
    localparam logic [NUM_SIZE-1:0] ALL_ONES = {NUM_SIZE{1'b1}};

    divState_e           state_r, nextState_s;
    logic [NUM_SIZE-1:0] opA_r, opB_r, q_r, rem_r, magB_r;
    logic [NUM_SIZE-1:0] quotient_r, remainder_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                isSigned_r, qNeg_r, rNeg_r, divZero_r, overflow_r;
    logic                busy_r, done_r;

    logic                accept_s;
    logic [NUM_SIZE-1:0] smAx_s, smBx_s, magA_s, magB_s, remShift_s;
    logic                smSigned_s, smAneg_s, smBneg_s, signA_s, signB_s;
    logic [NUM_SIZE:0]   trial_s;

    // Subtraction is done as a + ~b + 1 on the shared adder
    function automatic logic [NUM_SIZE:0] addCarry(input logic [NUM_SIZE:0] a,
                                                   input logic [NUM_SIZE:0] b,
                                                   input logic              cin);
        return a + b + {{NUM_SIZE{1'b0}}, cin};
    endfunction

    assign accept_s   = start && ((state_r == IDLE) || (state_r == DONE));
    assign remShift_s = {rem_r[NUM_SIZE-2:0], q_r[NUM_SIZE-1]};
    assign trial_s    = addCarry({1'b0, remShift_s}, {1'b1, ~magB_r}, 1'b1);

    // Decoders take the operands in PREP and negate the raw results in FIXUP
    always_comb begin
        smAx_s     = opA_r;
        smBx_s     = opB_r;
        smSigned_s = isSigned_r;
        smAneg_s   = 1'b0;
        smBneg_s   = 1'b0;
        if (state_r == FIXUP) begin
            smAx_s     = q_r;
            smBx_s     = rem_r;
            smSigned_s = 1'b0;
            smAneg_s   = qNeg_r;
            smBneg_s   = rNeg_r;
        end else begin
            smSigned_s = isSigned_r;
        end
    end

    sign_magnitude #(.NUM_SIZE(NUM_SIZE)) uDecA (
        .x(smAx_s), .isSigned(smSigned_s), .forceNeg(smAneg_s), .sign(signA_s), .mag(magA_s)
    );

    sign_magnitude #(.NUM_SIZE(NUM_SIZE)) uDecB (
        .x(smBx_s), .isSigned(smSigned_s), .forceNeg(smBneg_s), .sign(signB_s), .mag(magB_s)
    );

    // Next-state logic
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            IDLE:    nextState_s = accept_s ? PREP : IDLE;
            PREP:    nextState_s = DIVIDE;
            DIVIDE:  nextState_s = (cnt_r == '0) ? FIXUP : DIVIDE;
            FIXUP:   nextState_s = DONE;
            DONE:    nextState_s = accept_s ? PREP : IDLE;
            default: nextState_s = IDLE;
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_r     <= IDLE;
            opA_r       <= '0;
            opB_r       <= '0;
            q_r         <= '0;
            rem_r       <= '0;
            magB_r      <= '0;
            cnt_r       <= '0;
            isSigned_r  <= 1'b0;
            qNeg_r      <= 1'b0;
            rNeg_r      <= 1'b0;
            divZero_r   <= 1'b0;
            overflow_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            quotient_r  <= '0;
            remainder_r <= '0;
        end else begin
            state_r <= nextState_s;
            busy_r  <= (nextState_s == PREP) || (nextState_s == DIVIDE) || (nextState_s == FIXUP);
            done_r  <= (nextState_s == DONE);
            case (state_r)
                IDLE, DONE: begin
                    if (accept_s) begin
                        opA_r      <= dividend;
                        opB_r      <= divisor;
                        isSigned_r <= isSigned;
                    end
                end
                PREP: begin
                    q_r        <= magA_s;
                    rem_r      <= '0;
                    magB_r     <= magB_s;
                    cnt_r      <= CNT_LAST;
                    qNeg_r     <= signA_s ^ signB_s;
                    rNeg_r     <= signA_s;
                    divZero_r  <= (opB_r == '0);
                    overflow_r <= isSigned_r && (opA_r == MIN_NEG) && (opB_r == ALL_ONES);
                end
                DIVIDE: begin
                    q_r   <= {q_r[NUM_SIZE-2:0], ~trial_s[NUM_SIZE]};
                    rem_r <= trial_s[NUM_SIZE] ? remShift_s : trial_s[NUM_SIZE-1:0];
                    cnt_r <= cnt_r - CNT_W'(1);
                end
                FIXUP: begin
                    // Divide-by-zero outranks signed overflow
                    if (divZero_r) begin
                        quotient_r  <= ALL_ONES;
                        remainder_r <= opA_r;
                    end else if (overflow_r) begin
                        quotient_r  <= opA_r;
                        remainder_r <= '0;
                    end else begin
                        quotient_r  <= magA_s;
                        remainder_r <= magB_s;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign quotient  = quotient_r;
    assign remainder = remainder_r;

endmodule

// File: tb/tb_signed_divider.sv
// Scoreboard bench for signed_divider: expected results are queued at start
// and compared (values and latency) when done pulses.
module tb_signed_divider;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        start = 1'b0;
    logic        isSigned = 1'b0;
    logic [31:0] dividend = 32'd0;
    logic [31:0] divisor = 32'd0;
    logic        busy, done;
    logic [31:0] quotient, remainder;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          compared = 0;
    int          mismatched = 0;
    logic [31:0] lastQ = 32'd0;
    logic [31:0] lastR = 32'd0;

    signed_divider #(.NUM_SIZE(32)) dut (
        .clk(clk), .rstN(rstN), .start(start), .isSigned(isSigned),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic void refDiv(input logic [31:0] a, input logic [31:0] b, input logic s,
                                   output logic [31:0] q, output logic [31:0] r);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = 32'd0;
        end else if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Drives one start cycle from the current negedge and queues its expectation
    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [31:0] eq, input logic [31:0] er);
        dividend = a;
        divisor  = b;
        isSigned = s;
        start    = 1'b1;
        sb.push_back('{eq, er, cyc});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [31:0] eq, input logic [31:0] er);
        @(negedge clk);
        drive(a, b, s, eq, er);
    endtask

    task automatic issueModel(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] eq, er;
        refDiv(a, b, s, eq, er);
        issue(a, b, s, eq, er);
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        checkEq("drain_timeout", sb.size(), 32'd0);
        @(negedge clk);
    endtask

    // Scoreboard consumer
    always @(negedge clk) begin
        if (rstN && done) begin
            checkEq("busy_in_done", {31'd0, busy}, 32'd0);
            if (sb.size() == 0) begin
                checkEq("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkEq("quotient", quotient, e.q);
                checkEq("remainder", remainder, e.r);
                checkEq("latency", cyc - e.cyc, 32'd35);
                lastQ = e.q;
                lastR = e.r;
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        checkEq("rst_busy", {31'd0, busy}, 32'd0);
        checkEq("rst_done", {31'd0, done}, 32'd0);
        checkEq("rst_q", quotient, 32'd0);
        checkEq("rst_r", remainder, 32'd0);
        rstN = 1'b1;

        // Directed cases with known answers
        issue(32'hFFFF_FFF9, 32'h2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        drain();
        issue(32'hFFFF_FFFF, 32'h10, 1'b0, 32'h0FFF_FFFF, 32'hF);
        drain();
        issue(32'hFFFF_FFFF, 32'h10, 1'b1, 32'h0, 32'hFFFF_FFFF);
        drain();
        issue(32'h1234, 32'h0, 1'b1, 32'hFFFF_FFFF, 32'h1234);
        drain();
        issue(32'h1234, 32'h0, 1'b0, 32'hFFFF_FFFF, 32'h1234);
        drain();
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h0);
        drain();
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h8000_0000);
        drain();
        issue(32'h8000_0000, 32'h0, 1'b1, 32'hFFFF_FFFF, 32'h8000_0000);
        drain();

        // Start while busy is ignored; outputs hold the previous result meanwhile
        issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2);
        repeat (3) @(negedge clk);
        dividend = 32'd999;
        divisor  = 32'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkEq("busy_mid", {31'd0, busy}, 32'd1);
        checkEq("hold_q", quotient, lastQ);
        checkEq("hold_r", remainder, lastR);
        drain();

        // Back-to-back: next start lands in the DONE cycle
        issue(32'hFFFF_FF9C, 32'd9, 1'b1, 32'hFFFF_FFF5, 32'hFFFF_FFFF);
        for (int i = 0; i < 100; i++) begin
            if (done) break;
            @(negedge clk);
        end
        checkEq("b2b_done_seen", {31'd0, done}, 32'd1);
        drive(32'd77, 32'hFFFF_FFF6, 1'b1, 32'hFFFF_FFF9, 32'd7);
        drain();

        // Reset mid-operation aborts without a done pulse
        issue(32'd5000, 32'd3, 1'b0, 32'd1666, 32'd2);
        repeat (8) @(negedge clk);
        rstN = 1'b0;
        @(negedge clk);
        sb.delete();
        checkEq("abort_busy", {31'd0, busy}, 32'd0);
        checkEq("abort_done", {31'd0, done}, 32'd0);
        checkEq("abort_q", quotient, 32'd0);
        checkEq("abort_r", remainder, 32'd0);
        rstN = 1'b1;
        repeat (40) @(negedge clk);
        issue(32'd5000, 32'd3, 1'b0, 32'd1666, 32'd2);
        drain();

        // Randomised operands against the reference model
        for (int i = 0; i < 12; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(1, 50)) : $urandom;
            if (i % 4 == 1) b = -b;
            issueModel(a, b, 1'(i % 2));
            drain();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
